ariscv_fetch_queue: RTL and testbench
=====================================

ARISCV_FETCH_QUEUE -- requirements
Module: ariscv_fetch_queue

Interface
REQ-001 SHALL have parameter INST_NBW, default 32, instruction width.
REQ-002 SHALL have parameter PC_NBW, default 32, PC width.
REQ-003 SHALL have parameter DEPTH, default 4, queue entries; power of two, >=2.
REQ-004 SHALL have parameter RESET_PC, default 0, first fetch address.
REQ-005 SHALL have ports, in this order:
- aclk  in  1  single clock, rising edge
- rst_async_n  in  1  asynchronous, active-low reset
- i_redirect  in  1  flush and restart at i_redirect_pc
- i_redirect_pc  in  PC_NBW  redirect target
- o_imem_req_valid  out  1  fetch request valid
- i_imem_req_ready  in  1  imem accepts request
- o_imem_req_addr  out  PC_NBW  fetch address
- i_imem_rsp_valid  in  1  response valid; in order; no backpressure
- i_imem_rsp_inst  in  INST_NBW  response instruction
- o_valid  out  1  decode-side entry valid
- i_ready  in  1  decode accepts entry
- o_pc  out  PC_NBW  PC of head entry
- o_pc_plus4  out  PC_NBW  o_pc+4
- o_inst  out  INST_NBW  instruction of head entry

Function
REQ-006 SHALL hold fetch_pc; o_imem_req_addr = fetch_pc; fetch_pc += 4 on each request handshake (valid&ready), modulo 2^PC_NBW.
REQ-007 SHALL assert o_imem_req_valid iff occupancy + outstanding < DEPTH (credit rule), computed from registered state only; it SHALL NOT depend combinationally on i_redirect or i_imem_req_ready.
REQ-008 SHALL count outstanding: +1 on request handshake, -1 on each i_imem_rsp_valid, both allowed in the same cycle.
REQ-009 SHALL track rsp_pc; each kept response SHALL be enqueued with pc = rsp_pc and pc_plus4 = rsp_pc+4, then rsp_pc += 4.
REQ-010 SHALL present an enqueued entry on o_valid in the cycle after the response (latency 1, no bypass).
REQ-011 SHALL dequeue on o_valid&i_ready; o_pc/o_pc_plus4/o_inst SHALL hold while o_valid&!i_ready; enqueue and dequeue in the same cycle SHALL both occur.
REQ-012 SHALL implement FSM {RUN, FLUSH}; FLUSH is entered when drop_cnt>0 after a redirect; FLUSH returns to RUN when drop_cnt reaches 0.
REQ-013 On i_redirect: queue cleared next cycle; fetch_pc and rsp_pc <= {i_redirect_pc[PC_NBW-1:2],2'b00}; drop_cnt <= outstanding + (request handshake this cycle) - (response this cycle).
REQ-014 While drop_cnt>0, each response SHALL be discarded and drop_cnt decremented; it SHALL NOT be enqueued and SHALL NOT advance rsp_pc.
REQ-015 A response in the redirect cycle SHALL be discarded; a dequeue in the redirect cycle SHALL be ignored.
REQ-016 New requests SHALL be issued during FLUSH under REQ-007 credit rules.
REQ-017 Redirect during FLUSH SHALL recompute drop_cnt per REQ-013.

Reset
REQ-018 Reset SHALL give: fetch_pc = rsp_pc = RESET_PC; occupancy, outstanding and drop_cnt = 0; state RUN.
REQ-019 Outputs in reset SHALL be: o_valid=0, o_pc=o_pc_plus4=o_inst=0, o_imem_req_valid=0 (asserted from the first cycle after deassertion).
REQ-020 Reset asserted mid-operation SHALL discard all entries and in-flight tracking; responses to pre-reset requests are the environment's responsibility.

Structure
REQ-021 Package ariscv_pkg SHALL hold the INST_NBW/PC_NBW defaults and PC_INCR=4.
REQ-022 Storage SHALL be one sub-module, ariscv_sync_fifo (width PC_NBW+INST_NBW, depth DEPTH, synchronous clear); counters SHALL be $clog2(DEPTH)+1 bits.

Verification
REQ-023 Reset, i_imem_req_ready=1, response latency 1, i_ready=1 -> addresses 0,4,8,...; o_pc 0,4,8 with o_pc_plus4 4,8,12.
REQ-024 i_ready=0, DEPTH=4 -> exactly 4 handshakes, then o_imem_req_valid=0; one dequeue -> exactly one further request.
REQ-025 3 outstanding, response latency 3, redirect to 0x100 -> next 3 responses dropped; first o_pc=0x100.
REQ-026 Redirect to 0x103 with a response and a handshake in the same cycle -> that response dropped, drop_cnt includes the handshake, next address 0x100.
REQ-027 RESET_PC=0xFFFFFFF8 -> addresses FFFFFFF8, FFFFFFFC, 00000000; o_pc_plus4 of FFFFFFFC = 0.
REQ-028 Reset asserted with 2 entries queued -> o_valid=0 immediately; first address after release = RESET_PC.

Source files
------------

// File: rtl/ariscv_pkg.sv
// Shared constants for the ariscv fetch path.
package ariscv_pkg;

  localparam int unsigned INST_NBW = 32;
  localparam int unsigned PC_NBW   = 32;
  localparam int unsigned PC_INCR  = 4;

endpackage

// File: rtl/ariscv_fetch_queue_if.sv
// Bundle of the fetch queue's redirect, imem and decode-side handshake signals.
interface ariscv_fetch_queue_if #(
  parameter int unsigned PC_NBW   = ariscv_pkg::PC_NBW,
  parameter int unsigned INST_NBW = ariscv_pkg::INST_NBW
) ();

  logic                redirect;
  logic [PC_NBW-1:0]   redirect_pc;
  logic                imem_req_valid;
  logic                imem_req_ready;
  logic [PC_NBW-1:0]   imem_req_addr;
  logic                imem_rsp_valid;
  logic [INST_NBW-1:0] imem_rsp_inst;
  logic                valid;
  logic                ready;
  logic [PC_NBW-1:0]   pc;
  logic [PC_NBW-1:0]   pc_plus4;
  logic [INST_NBW-1:0] inst;

  // Fetch queue side.
  modport master (
    input  redirect, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_inst, ready,
    output imem_req_valid, imem_req_addr, valid, pc, pc_plus4, inst
  );

  // Core / memory environment side.
  modport slave (
    output redirect, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_inst, ready,
    input  imem_req_valid, imem_req_addr, valid, pc, pc_plus4, inst
  );

endinterface

// File: rtl/ariscv_sync_fifo.sv
// Power-of-two synchronous FIFO with synchronous clear; head is read combinationally.
module ariscv_sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full;
  logic             do_push, do_pop;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_data = mem[rd_ptr_q];

  // Pointer and occupancy tracking; clear wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Entry storage; stale contents are never visible because outputs qualify on occupancy.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ariscv_fetch_queue.sv
// Instruction fetch queue: credit-limited imem requests, in-order responses, redirect flush.
module ariscv_fetch_queue #(
  parameter int unsigned INST_NBW = ariscv_pkg::INST_NBW,
  parameter int unsigned PC_NBW   = ariscv_pkg::PC_NBW,
  parameter int unsigned DEPTH    = 4,
  parameter logic [PC_NBW-1:0] RESET_PC = '0
) (
  input  logic                aclk,
  input  logic                rst_async_n,
  input  logic                i_redirect,
  input  logic [PC_NBW-1:0]   i_redirect_pc,
  output logic                o_imem_req_valid,
  input  logic                i_imem_req_ready,
  output logic [PC_NBW-1:0]   o_imem_req_addr,
  input  logic                i_imem_rsp_valid,
  input  logic [INST_NBW-1:0] i_imem_rsp_inst,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [PC_NBW-1:0]   o_pc,
  output logic [PC_NBW-1:0]   o_pc_plus4,
  output logic [INST_NBW-1:0] o_inst
);

  import ariscv_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [0:0]  StRun   = 1'b0;
  localparam logic [0:0]  StFlush = 1'b1;
  localparam logic [PC_NBW-1:0] PcIncr = PC_NBW'(PC_INCR);

  logic [0:0]        state_q, state_d;
  logic [PC_NBW-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_NBW-1:0] rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic              started_q;

  logic [CNT_W-1:0]  occupancy;
  logic              fifo_empty;
  logic [PC_NBW+INST_NBW-1:0] head;
  logic              req_hs;
  logic              keep_rsp;
  logic              deq;
  logic [PC_NBW-1:0] redirect_aligned;

  // Credit counts entries already queued plus responses still in flight, so the
  // FIFO can never overflow; started_q holds requests off during reset.
  assign o_imem_req_valid = started_q &
      (({1'b0, occupancy} + {1'b0, outstanding_q}) < (CNT_W + 1)'(DEPTH));
  assign o_imem_req_addr  = fetch_pc_q;
  assign req_hs           = o_imem_req_valid & i_imem_req_ready;
  assign keep_rsp         = i_imem_rsp_valid & ~i_redirect & (state_q == StRun);
  assign deq              = o_valid & i_ready & ~i_redirect;
  assign redirect_aligned = i_redirect_pc & ~PC_NBW'(3);

  assign o_valid    = ~fifo_empty;
  assign o_pc       = o_valid ? head[PC_NBW+INST_NBW-1:INST_NBW] : '0;
  assign o_pc_plus4 = o_valid ? head[PC_NBW+INST_NBW-1:INST_NBW] + PcIncr : '0;
  assign o_inst     = o_valid ? head[INST_NBW-1:0] : '0;

  // Next-state: in-flight count, drop budget, fetch/response PCs and flush FSM.
  always_comb begin
    outstanding_d = outstanding_q + CNT_W'(req_hs) - CNT_W'(i_imem_rsp_valid);
    drop_cnt_d    = drop_cnt_q;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    if (i_redirect) begin
      // Everything still in flight after this cycle belongs to the old stream.
      drop_cnt_d = outstanding_d;
      fetch_pc_d = redirect_aligned;
      rsp_pc_d   = redirect_aligned;
    end else begin
      if (state_q == StFlush && i_imem_rsp_valid) drop_cnt_d = drop_cnt_q - CNT_W'(1);
      if (req_hs)   fetch_pc_d = fetch_pc_q + PcIncr;
      if (keep_rsp) rsp_pc_d   = rsp_pc_q + PcIncr;
    end
    state_d = (drop_cnt_d != '0) ? StFlush : StRun;
  end

  // State registers.
  always_ff @(posedge aclk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      state_q       <= StRun;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      started_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      started_q     <= 1'b1;
    end
  end

  ariscv_sync_fifo #(
    .WIDTH (PC_NBW + INST_NBW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (aclk),
    .rst_n     (rst_async_n),
    .clear     (i_redirect),
    .push      (keep_rsp),
    .push_data ({rsp_pc_q, i_imem_rsp_inst}),
    .pop       (deq),
    .head_data (head),
    .empty     (fifo_empty),
    .count     (occupancy)
  );

endmodule

// File: tb/tb_ariscv_fetch_queue.sv
// Scoreboard bench for ariscv_fetch_queue with a latency-programmable imem model.
module tb_ariscv_fetch_queue;

  localparam int unsigned PC_NBW   = 32;
  localparam int unsigned INST_NBW = 32;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RST_PC   = 32'hFFFF_FFF8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] inst;
  } out_t;

  typedef struct packed {
    int          due;
    logic [31:0] addr;
  } pend_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ariscv_fetch_queue_if #(.PC_NBW(PC_NBW), .INST_NBW(INST_NBW)) ifc ();

  ariscv_fetch_queue #(
    .INST_NBW (INST_NBW),
    .PC_NBW   (PC_NBW),
    .DEPTH    (DEPTH),
    .RESET_PC (RST_PC)
  ) dut (
    .aclk             (clk),
    .rst_async_n      (rst_n),
    .i_redirect       (ifc.redirect),
    .i_redirect_pc    (ifc.redirect_pc),
    .o_imem_req_valid (ifc.imem_req_valid),
    .i_imem_req_ready (ifc.imem_req_ready),
    .o_imem_req_addr  (ifc.imem_req_addr),
    .i_imem_rsp_valid (ifc.imem_rsp_valid),
    .i_imem_rsp_inst  (ifc.imem_rsp_inst),
    .o_valid          (ifc.valid),
    .i_ready          (ifc.ready),
    .o_pc             (ifc.pc),
    .o_pc_plus4       (ifc.pc_plus4),
    .o_inst           (ifc.inst)
  );

  logic [31:0] exp_addr[$];
  out_t        exp_out[$];
  pend_t       pend[$];
  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;
  int cyc      = 0;
  int lat      = 1;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_req(input logic [31:0] a);
    exp_addr.push_back(a);
  endtask

  task automatic exp_o(input logic [31:0] pc, input logic [31:0] plus4);
    exp_out.push_back('{pc: pc, pc_plus4: plus4, inst: inst_of(pc)});
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: request handshakes and decode-side dequeues against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ifc.imem_req_valid && ifc.imem_req_ready) begin
        hs_cnt++;
        pend.push_back('{due: cyc + lat, addr: ifc.imem_req_addr});
        if (exp_addr.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL req_unexpected: got addr %h required no request", ifc.imem_req_addr);
        end else begin
          check32("req_addr", ifc.imem_req_addr, exp_addr.pop_front());
        end
      end
      if (ifc.valid && ifc.ready && !ifc.redirect) begin
        if (exp_out.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL deq_unexpected: got pc %h required no entry", ifc.pc);
        end else begin
          out_t e;
          e = exp_out.pop_front();
          check32("o_pc", ifc.pc, e.pc);
          check32("o_pc_plus4", ifc.pc_plus4, e.pc_plus4);
          check32("o_inst", ifc.inst, e.inst);
        end
      end
    end
  end

  // Imem model: in-order responses a fixed number of cycles after each handshake.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      pend.delete();
      ifc.imem_rsp_valid = 1'b0;
      ifc.imem_rsp_inst  = '0;
    end else if (pend.size() > 0 && pend[0].due == cyc) begin
      ifc.imem_rsp_valid = 1'b1;
      ifc.imem_rsp_inst  = inst_of(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      ifc.imem_rsp_valid = 1'b0;
      ifc.imem_rsp_inst  = '0;
    end
  end

  // Hold request ready until n more handshakes; optionally leave it high.
  task automatic grant(input int n, input bit keep);
    int target;
    bit done;
    target = hs_cnt + n;
    done = 1'b0;
    ifc.imem_req_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (hs_cnt >= target) begin
        done = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL grant_timeout: got %0d handshakes required %0d", hs_cnt, target);
    end
    @(posedge clk);
    #1;
    if (!keep) ifc.imem_req_ready = 1'b0;
  endtask

  // Wait for all expected traffic to be observed and the imem model to go idle.
  task automatic settle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (exp_addr.size() == 0 && exp_out.size() == 0 && pend.size() == 0 &&
          !ifc.imem_rsp_valid) begin
        done = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d reqs %0d entries pending required 0 0", name,
               exp_addr.size(), exp_out.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    ifc.redirect       = 1'b0;
    ifc.redirect_pc    = '0;
    ifc.imem_req_ready = 1'b0;
    ifc.ready          = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check32("rst_o_valid", 32'(ifc.valid), 32'd0);
    check32("rst_o_pc", ifc.pc, 32'd0);
    check32("rst_o_pc_plus4", ifc.pc_plus4, 32'd0);
    check32("rst_o_inst", ifc.inst, 32'd0);
    check32("rst_req_valid", 32'(ifc.imem_req_valid), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check32("first_req_valid", 32'(ifc.imem_req_valid), 32'd1);
    check32("first_req_addr", ifc.imem_req_addr, RST_PC);

    // PC wrap from RESET_PC near the top of the address space.
    ifc.ready = 1'b1;
    lat = 1;
    exp_req(32'hFFFF_FFF8); exp_req(32'hFFFF_FFFC); exp_req(32'h0000_0000);
    exp_o(32'hFFFF_FFF8, 32'hFFFF_FFFC);
    exp_o(32'hFFFF_FFFC, 32'h0000_0000);
    exp_o(32'h0000_0000, 32'h0000_0004);
    grant(3, 1'b0);
    settle("wrap");

    // Idle redirect to 0, then streaming fetch.
    ifc.redirect = 1'b1; ifc.redirect_pc = 32'h0;
    @(posedge clk);
    #1;
    ifc.redirect = 1'b0;
    exp_req(32'h0); exp_req(32'h4); exp_req(32'h8); exp_req(32'hC);
    exp_o(32'h0, 32'h4); exp_o(32'h4, 32'h8); exp_o(32'h8, 32'hC); exp_o(32'hC, 32'h10);
    grant(4, 1'b0);
    settle("stream");

    // Credit limit under decode backpressure.
    ifc.ready = 1'b0;
    exp_req(32'h10); exp_req(32'h14); exp_req(32'h18); exp_req(32'h1C); exp_req(32'h20);
    exp_o(32'h10, 32'h14); exp_o(32'h14, 32'h18); exp_o(32'h18, 32'h1C);
    exp_o(32'h1C, 32'h20); exp_o(32'h20, 32'h24);
    base = hs_cnt;
    ifc.imem_req_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check32("credit_hs", 32'(hs_cnt - base), 32'd4);
    check32("credit_req_valid", 32'(ifc.imem_req_valid), 32'd0);
    check32("hold_valid", 32'(ifc.valid), 32'd1);
    check32("hold_pc", ifc.pc, 32'h10);
    ifc.ready = 1'b1;
    @(posedge clk);
    #1;
    ifc.ready = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check32("credit_hs_after_deq", 32'(hs_cnt - base), 32'd5);
    check32("credit_req_valid2", 32'(ifc.imem_req_valid), 32'd0);
    ifc.imem_req_ready = 1'b0;
    ifc.ready = 1'b1;
    settle("credit");

    // Redirect with three requests in flight at latency 3; requests issue during flush.
    lat = 3;
    exp_req(32'h24); exp_req(32'h28); exp_req(32'h2C); exp_req(32'h100); exp_req(32'h104);
    exp_o(32'h100, 32'h104); exp_o(32'h104, 32'h108);
    grant(3, 1'b0);
    ifc.redirect = 1'b1; ifc.redirect_pc = 32'h100;
    @(posedge clk);
    #1;
    ifc.redirect = 1'b0;
    grant(2, 1'b0);
    settle("flush");
    lat = 1;

    // Unaligned redirect coinciding with a response and a request handshake.
    exp_req(32'h108); exp_req(32'h10C); exp_req(32'h110); exp_req(32'h100);
    exp_o(32'h100, 32'h104);
    grant(2, 1'b1);
    ifc.redirect = 1'b1; ifc.redirect_pc = 32'h103;
    @(posedge clk);
    #1;
    ifc.redirect = 1'b0;
    ifc.imem_req_ready = 1'b0;
    check32("redir_addr", ifc.imem_req_addr, 32'h100);
    grant(1, 1'b0);
    settle("same_cycle");

    // Reset with entries queued.
    ifc.ready = 1'b0;
    exp_req(32'h104); exp_req(32'h108);
    grant(2, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check32("pre_rst_valid", 32'(ifc.valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check32("mid_rst_valid", 32'(ifc.valid), 32'd0);
    check32("mid_rst_req_valid", 32'(ifc.imem_req_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ifc.ready = 1'b1;
    exp_req(RST_PC);
    exp_o(RST_PC, 32'hFFFF_FFFC);
    @(posedge clk);
    #1;
    grant(1, 1'b0);
    settle("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
